// File: rtl/mm_pkg.sv
// Shared defaults, pipeline payload type and saturation bounds for the mm_requant block.
package mm_pkg;

  localparam int unsigned DefDWAcc       = 32;
  localparam int unsigned DefDW          = 8;
  localparam int unsigned DefMultW       = 16;
  localparam int unsigned DefShiftW      = 6;
  localparam int unsigned DefMatrixSizeW = 24;

  // Internal stage width; the product (D_W_ACC+MULT_W+1 bits) must stay below it so the
  // rounding add cannot overflow.
  localparam int unsigned StageW = 64;

  typedef struct packed {
    logic [StageW-1:0] data;
    logic              last;
  } stage_t;

  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Zero-point add, optional quantized ReLU (REQUANT_RELU_EN) and saturation to D_W bits.
module requant_sat
  import mm_pkg::*;
#(
  parameter int unsigned R_W = StageW,
  parameter int unsigned D_W = DefDW
) (
  input  logic signed [R_W-1:0] r,
  input  logic signed [D_W-1:0] zero_pt,
  output logic signed [D_W-1:0] q
);

  localparam int unsigned SW = R_W + 1;
  localparam logic signed [SW-1:0] Hi = SW'(sat_hi(D_W));
  localparam logic signed [SW-1:0] Lo = SW'(sat_lo(D_W));

  logic signed [SW-1:0] zp_ext;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] clamped;

  always_comb begin
    zp_ext = $signed({{(SW - D_W){zero_pt[D_W-1]}}, zero_pt});
    sum    = $signed({r[R_W-1], r}) + zp_ext;
`ifdef REQUANT_RELU_EN
    // Real-valued zero maps to zero_pt, so that is the ReLU floor.
    clamped = (sum < zp_ext) ? zp_ext : sum;
`else
    clamped = sum;
`endif
    if (clamped > Hi) begin
      q = Hi[D_W-1:0];
    end else if (clamped < Lo) begin
      q = Lo[D_W-1:0];
    end else begin
      q = clamped[D_W-1:0];
    end
  end

endmodule

// File: rtl/mm_requant.sv
// Three-stage requantizer for the matrix-multiply output stream: multiply, round/shift,
// zero-point add and saturate. Frame framing comes from an element counter; REQUANT_RELU_EN
// enables the quantized ReLU clamp in requant_sat.
module mm_requant
  import mm_pkg::*;
#(
  parameter int unsigned D_W_ACC      = DefDWAcc,
  parameter int unsigned D_W          = DefDW,
  parameter int unsigned MULT_W       = DefMultW,
  parameter int unsigned SHIFT_W      = DefShiftW,
  parameter int unsigned MATRIXSIZE_W = DefMatrixSizeW
) (
  input  logic                    mm_clk,
  input  logic                    mm_rst_n,
  input  logic [D_W_ACC-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [D_W-1:0]          m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic [MULT_W-1:0]       mult,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic [D_W-1:0]          zero_pt,
  input  logic [MATRIXSIZE_W-1:0] n_elem,
  output logic                    err_len
);

  localparam int unsigned P_W = D_W_ACC + MULT_W + 1;

  logic                    en;
  logic                    accept;
  logic                    last_tag;
  logic                    first_q;
  logic [MATRIXSIZE_W-1:0] cnt_q;
  logic [MATRIXSIZE_W-1:0] n_elem_q;
  logic [MATRIXSIZE_W-1:0] n_eff;
  logic [MULT_W-1:0]       mult_q;
  logic [MULT_W-1:0]       mult_eff;
  logic [SHIFT_W-1:0]      shift_q;
  logic [SHIFT_W-1:0]      shift_eff;
  logic [D_W-1:0]          zero_pt_q;
  logic [D_W-1:0]          zp_eff;
  logic                    err_q;

  logic                    v1_q, v2_q, v3_q;
  stage_t                  s1_q, s2_q;
  logic [SHIFT_W-1:0]      sh1_q;
  logic [D_W-1:0]          zp1_q, zp2_q;
  logic [D_W-1:0]          m_data_q;
  logic                    m_last_q;

  logic signed [P_W-1:0]    acc_ext;
  logic signed [P_W-1:0]    mult_ext;
  logic signed [P_W-1:0]    prod;
  logic signed [StageW-1:0] p1;
  logic signed [StageW-1:0] rnd;
  logic signed [StageW-1:0] r2;
  logic signed [D_W-1:0]    q3;

  always_comb begin
    en     = ~v3_q | m_axis_tready;
    accept = s_axis_tvalid & en;

    // The first beat of a frame uses the live config; later beats use the shadow copy.
    mult_eff  = first_q ? mult    : mult_q;
    shift_eff = first_q ? shift   : shift_q;
    zp_eff    = first_q ? zero_pt : zero_pt_q;
    n_eff     = first_q ? n_elem  : n_elem_q;
    last_tag  = (cnt_q == n_eff - 1'b1);

    acc_ext  = $signed({{(MULT_W + 1){s_axis_tdata[D_W_ACC-1]}}, s_axis_tdata});
    mult_ext = $signed({{(D_W_ACC + 1){1'b0}}, mult_eff});
    prod     = acc_ext * mult_ext;

    p1  = $signed(s1_q.data);
    rnd = (sh1_q != '0) ? (StageW'(1) << (sh1_q - 1'b1)) : '0;
    r2  = (p1 + rnd) >>> sh1_q;
  end

  requant_sat #(
    .R_W (StageW),
    .D_W (D_W)
  ) u_requant_sat (
    .r       ($signed(s2_q.data)),
    .zero_pt ($signed(zp2_q)),
    .q       (q3)
  );

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      first_q   <= 1'b1;
      cnt_q     <= '0;
      n_elem_q  <= '0;
      mult_q    <= '0;
      shift_q   <= '0;
      zero_pt_q <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      if (first_q) begin
        mult_q    <= mult;
        shift_q   <= shift;
        zero_pt_q <= zero_pt;
        n_elem_q  <= n_elem;
      end
      cnt_q   <= last_tag ? '0 : cnt_q + 1'b1;
      first_q <= last_tag;
      if (s_axis_tlast != last_tag) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge mm_clk or negedge mm_rst_n) begin
    if (!mm_rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      sh1_q    <= '0;
      zp1_q    <= '0;
      zp2_q    <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else if (en) begin
      v1_q     <= s_axis_tvalid;
      s1_q     <= '{data: {{(StageW - P_W){prod[P_W-1]}}, prod}, last: last_tag};
      sh1_q    <= shift_eff;
      zp1_q    <= zp_eff;
      v2_q     <= v1_q;
      s2_q     <= '{data: r2, last: s1_q.last};
      zp2_q    <= zp1_q;
      v3_q     <= v2_q;
      m_data_q <= q3;
      m_last_q <= s2_q.last;
    end
  end

  assign s_axis_tready = en;
  assign m_axis_tvalid = v3_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign err_len       = err_q;

endmodule
